// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forwarding select encodings
// and the scoreboard counter width helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Bits needed to hold the longest pending-write count.
    function automatic int unsigned lat_width(input int unsigned load_lat,
                                              input int unsigned mul_lat,
                                              input int unsigned wb_dist);
        int unsigned max_lat;
        max_lat = (load_lat > mul_lat) ? load_lat : mul_lat;
        return (max_lat + wb_dist < 2) ? 1 : $clog2(max_lat + wb_dist + 1);
    endfunction

endpackage

// File: rtl/hazard_sb_cnt.sv
// One scoreboard entry: saturating down-counter with a priority load.
module hazard_sb_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    // A reload in the same cycle wins over the decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: per-register pending-write scoreboard, EX/MEM
// destination tracking, stall/flush generation, forwarding and branch resolve.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned WB_DIST  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid_d,
    input  logic [ADDR_W-1:0] src1_addr_d,
    input  logic [ADDR_W-1:0] src2_addr_d,
    input  logic              src2_used_d,
    input  logic [DATA_W-1:0] src1_data_d,
    input  logic [DATA_W-1:0] src2_data_d,
    input  logic [ADDR_W-1:0] rd_addr_d,
    input  logic              reg_write_d,
    input  logic              is_load_d,
    input  logic              is_mul_d,
    input  logic              branch_d,
    input  logic              fwd_en,
    input  logic              flush_req,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              branch_taken,
    output logic              mul_busy
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned CNT_W = lat_width(LOAD_LAT, MUL_LAT, WB_DIST);
    localparam int unsigned MUL_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    logic [CNT_W-1:0]  cnt [NREG];
    logic [CNT_W-1:0]  load_val;
    logic [MUL_W-1:0]  mul_cnt;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_wr;
    logic [ADDR_W-1:0] mem_rd;
    logic              mem_wr;
    logic              issue;
    logic              data_haz;
    logic              struct_haz;
    logic              hazard;

    // Pending-write count for the decode destination.
    always_comb begin
        load_val = '0;
        if (is_load_d) begin
            load_val = CNT_W'(LOAD_LAT - 1);
        end else if (is_mul_d) begin
            load_val = CNT_W'(MUL_LAT - 1);
        end
        if (!fwd_en) begin
            load_val = load_val + CNT_W'(WB_DIST);
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_sb
        hazard_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (issue & reg_write_d & (rd_addr_d == ADDR_W'(g))),
            .load_val (load_val),
            .cnt      (cnt[g])
        );
    end

    // Multiplier occupancy: reloads on every multiply that issues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_cnt <= '0;
        end else if (issue && is_mul_d) begin
            mul_cnt <= MUL_W'(MUL_LAT);
        end else if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - MUL_W'(1);
        end
    end

    // Destination tracking; a stalled or empty decode slot becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_rd  <= '0;
            ex_wr  <= 1'b0;
            mem_rd <= '0;
            mem_wr <= 1'b0;
        end else begin
            ex_rd  <= issue ? rd_addr_d : ex_rd;
            ex_wr  <= issue & reg_write_d;
            mem_rd <= ex_rd;
            mem_wr <= ex_wr;
        end
    end

    always_comb begin
        mul_busy     = (mul_cnt != '0);
        data_haz     = issue_valid_d &
                       ((cnt[src1_addr_d] != '0) | (src2_used_d & (cnt[src2_addr_d] != '0)));
        struct_haz   = issue_valid_d & is_mul_d & mul_busy;
        hazard       = data_haz | struct_haz;
        stall_f      = hazard;
        stall_d      = hazard;
        issue        = issue_valid_d & ~hazard;
        branch_taken = issue & branch_d & (src1_data_d != src2_data_d);
        flush_d      = branch_taken;
        flush_e      = hazard | (branch_taken & flush_req);
    end

    // Operand selects: youngest in-flight producer wins.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (fwd_en && (cnt[src1_addr_d] == '0)) begin
            if (ex_wr && (ex_rd == src1_addr_d)) begin
                fwd_a = FWD_EX;
            end else if (mem_wr && (mem_rd == src1_addr_d)) begin
                fwd_a = FWD_MEM;
            end
        end
        if (fwd_en && src2_used_d && (cnt[src2_addr_d] == '0)) begin
            if (ex_wr && (ex_rd == src2_addr_d)) begin
                fwd_b = FWD_EX;
            end else if (mem_wr && (mem_rd == src2_addr_d)) begin
                fwd_b = FWD_MEM;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              issue_valid_d;
    logic [ADDR_W-1:0] src1_addr_d;
    logic [ADDR_W-1:0] src2_addr_d;
    logic              src2_used_d;
    logic [DATA_W-1:0] src1_data_d;
    logic [DATA_W-1:0] src2_data_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              reg_write_d;
    logic              is_load_d;
    logic              is_mul_d;
    logic              branch_d;
    logic              fwd_en;
    logic              flush_req;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              branch_taken;
    logic              mul_busy;

    int n_checks;
    int n_errors;

    hazard_scoreboard #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LOAD_LAT (2),
        .MUL_LAT  (4),
        .WB_DIST  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_d (issue_valid_d),
        .src1_addr_d   (src1_addr_d),
        .src2_addr_d   (src2_addr_d),
        .src2_used_d   (src2_used_d),
        .src1_data_d   (src1_data_d),
        .src2_data_d   (src2_data_d),
        .rd_addr_d     (rd_addr_d),
        .reg_write_d   (reg_write_d),
        .is_load_d     (is_load_d),
        .is_mul_d      (is_mul_d),
        .branch_d      (branch_d),
        .fwd_en        (fwd_en),
        .flush_req     (flush_req),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .branch_taken  (branch_taken),
        .mul_busy      (mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one decode slot just after the edge, leaving time to settle.
    task automatic drive(input logic v, input int s1, input int s2, input logic u2,
                         input int rd, input logic wr, input logic ld, input logic mul,
                         input logic br, input int d1, input int d2);
        @(posedge clk);
        #1;
        issue_valid_d = v;
        src1_addr_d   = ADDR_W'(s1);
        src2_addr_d   = ADDR_W'(s2);
        src2_used_d   = u2;
        rd_addr_d     = ADDR_W'(rd);
        reg_write_d   = wr;
        is_load_d     = ld;
        is_mul_d      = mul;
        branch_d      = br;
        src1_data_d   = DATA_W'(d1);
        src2_data_d   = DATA_W'(d2);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic expect_out(input string tag, input logic st, input logic fd, input logic fe,
                              input logic [1:0] fa, input logic [1:0] fb, input logic bt,
                              input logic mb);
        check({tag, ".stall_f"}, 32'(stall_f), 32'(st));
        check({tag, ".stall_d"}, 32'(stall_d), 32'(st));
        check({tag, ".flush_d"}, 32'(flush_d), 32'(fd));
        check({tag, ".flush_e"}, 32'(flush_e), 32'(fe));
        check({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
        check({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
        check({tag, ".taken"}, 32'(branch_taken), 32'(bt));
        check({tag, ".mul_busy"}, 32'(mul_busy), 32'(mb));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        fwd_en        = 1'b1;
        flush_req     = 1'b0;
        issue_valid_d = 1'b0;
        src1_addr_d   = '0;
        src2_addr_d   = '0;
        src2_used_d   = 1'b0;
        src1_data_d   = '0;
        src2_data_d   = '0;
        rd_addr_d     = '0;
        reg_write_d   = 1'b0;
        is_load_d     = 1'b0;
        is_mul_d      = 1'b0;
        branch_d      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        idle();
        expect_out("reset", 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // ALU producer chain on r3: EX beats MEM when both hold r3
        drive(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
        expect_out("alu_prod", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        drive(1, 3, 4, 1, 3, 1, 0, 0, 0, 0, 0);
        expect_out("alu_use_ex", 0, 0, 0, 2'b01, 2'b00, 0, 0);
        drive(1, 3, 3, 1, 7, 0, 0, 0, 0, 0, 0);
        expect_out("ex_over_mem", 0, 0, 0, 2'b01, 2'b01, 0, 0);
        drive(1, 3, 3, 0, 7, 0, 0, 0, 0, 0, 0);
        expect_out("alu_use_mem", 0, 0, 0, 2'b10, 2'b00, 0, 0);
        idle();

        // Load-use on r5: one stall cycle, then MEM forward on operand B
        drive(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        expect_out("load_issue", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        drive(1, 1, 5, 1, 11, 0, 0, 0, 0, 0, 0);
        expect_out("load_use_stall", 1, 0, 1, 2'b00, 2'b00, 0, 0);
        drive(1, 1, 5, 1, 11, 0, 0, 0, 0, 0, 0);
        expect_out("load_use_go", 0, 0, 0, 2'b00, 2'b10, 0, 0);
        idle();

        // Back-to-back multiplies: second waits MUL_LAT cycles
        drive(1, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0);
        expect_out("mul1", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 9, 1, 0, 1, 0, 0, 0);
            expect_out($sformatf("mul2_stall%0d", i), 1, 0, 1, 2'b00, 2'b00, 0, 1);
        end
        drive(1, 1, 0, 0, 9, 1, 0, 1, 0, 0, 0);
        expect_out("mul2_go", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle();
        expect_out("mul2_busy", 0, 0, 0, 2'b00, 2'b00, 0, 1);
        repeat (4) idle();

        // Forwarding off: reader of r2 waits WB_DIST cycles, no forwarding
        fwd_en = 1'b0;
        drive(1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        expect_out("nofwd_prod", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 2, 0, 0, 12, 0, 0, 0, 0, 0, 0);
            expect_out($sformatf("nofwd_stall%0d", i), 1, 0, 1, 2'b00, 2'b00, 0, 0);
        end
        drive(1, 2, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        expect_out("nofwd_go", 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // Branch resolution with flush_req set
        fwd_en    = 1'b1;
        flush_req = 1'b1;
        drive(1, 1, 4, 1, 0, 0, 0, 0, 1, 'h1234, 'h1235);
        expect_out("br_taken", 0, 1, 1, 2'b00, 2'b00, 1, 0);
        drive(1, 1, 4, 1, 0, 0, 0, 0, 1, 'h1234, 'h1234);
        expect_out("br_not_taken", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        drive(1, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0);
        expect_out("br_load", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        drive(1, 10, 4, 1, 0, 0, 0, 0, 1, 'h1234, 'h1235);
        expect_out("br_stalled", 1, 0, 1, 2'b00, 2'b00, 0, 0);
        drive(1, 10, 4, 1, 0, 0, 0, 0, 1, 'h1234, 'h1235);
        expect_out("br_retry", 0, 1, 1, 2'b10, 2'b00, 1, 0);

        // Reset while a long load to r5 is pending
        flush_req = 1'b0;
        fwd_en    = 1'b0;
        drive(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        expect_out("rst_load", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle();
        rst_n  = 1'b0;
        fwd_en = 1'b1;
        drive(1, 5, 0, 0, 13, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        expect_out("rst_reader", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        idle();
        expect_out("rst_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
